// File: rtl/burst_serial_slave.sv
// burst_serial_slave: bit-serial bus slave decoding ID/address/burst headers and running
// single or burst reads/writes against a local parallel port. Optional macro PARITY_EN.
module burst_serial_slave #(
    parameter int                  ID_WIDTH       = 3,
    parameter logic [ID_WIDTH-1:0] SELF_ID        = 3'b110,
    parameter int                  ADDRESS_WIDTH  = 15,
    parameter int                  DATA_WIDTH     = 8,
    parameter int                  BURST_WIDTH    = 2,
    parameter int                  TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bus_util,
    input  logic                     rd_wrt,
    inout  wire                      data_bus_serial,
    input  logic                     arbiter_cmd_in,
    input  logic                     module_dv,
    input  logic [DATA_WIDTH-1:0]    data_in_parallel,
    output logic                     write_en_internal,
    output logic                     rd_req,
    output logic [DATA_WIDTH-1:0]    data_out_parallel,
    output logic [ADDRESS_WIDTH-1:0] addr_buff,
    output logic                     busy_out,
    output logic                     err_out
);
`ifdef PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int CW = $clog2(ID_WIDTH + ADDRESS_WIDTH + DATA_WIDTH + BURST_WIDTH + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] ID_LAST   = CW'(ID_WIDTH - 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDRESS_WIDTH - 1);
    localparam logic [CW-1:0] LEN_LAST  = CW'(BURST_WIDTH - 1);
    localparam logic [CW-1:0] DW_C      = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] DW_LAST   = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(DATA_WIDTH + PAR_BITS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_ADDR, S_LEN, S_WR_DATA, S_WR_STB,
        S_RD_REQ, S_RD_WAIT, S_RD_GRANT, S_RD_SHIFT, S_HOLD
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            cnt_q;
    logic [TW-1:0]            tmo_q;
    logic [ID_WIDTH-1:0]      id_q;
    logic [BURST_WIDTH-1:0]   beats_q;
    logic [DATA_WIDTH-1:0]    sh_q;
    logic [DATA_WIDTH-1:0]    dout_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     wen_q, rdreq_q, busy_q, err_q, drv_en_q, drv_bit_q;
`ifdef PARITY_EN
    logic                     par_q;
`endif
    logic                     bus_bit;

    assign bus_bit           = data_bus_serial;
    assign data_bus_serial   = drv_en_q ? drv_bit_q : 1'bz;
    assign write_en_internal = wen_q;
    assign rd_req            = rdreq_q;
    assign data_out_parallel = dout_q;
    assign addr_buff         = addr_q;
    assign busy_out          = busy_q;
    assign err_out           = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            id_q      <= '0;
            beats_q   <= '0;
            sh_q      <= '0;
            dout_q    <= '0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            rdreq_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            drv_en_q  <= 1'b0;
            drv_bit_q <= 1'b0;
`ifdef PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            wen_q   <= 1'b0;
            rdreq_q <= 1'b0;
            err_q   <= 1'b0;
            // Bus going idle mid-transaction wins over everything, including HOLD's normal exit.
            if (state_q != S_IDLE && bus_util) begin
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
                drv_en_q  <= 1'b0;
                drv_bit_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: if (!bus_util) begin
                        id_q    <= ID_WIDTH'(bus_bit);
                        cnt_q   <= CW'(1);
                        state_q <= S_ID;
                    end
                    S_ID: begin
                        id_q  <= ID_WIDTH'({id_q, bus_bit});
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == ID_LAST) begin
                            cnt_q <= '0;
                            if (ID_WIDTH'({id_q, bus_bit}) == SELF_ID) begin
                                busy_q  <= 1'b1;
                                state_q <= S_ADDR;
                            end else begin
                                state_q <= S_HOLD;
                            end
                        end
                    end
                    S_ADDR: begin
                        addr_q <= ADDRESS_WIDTH'({addr_q, bus_bit});
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == ADDR_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        beats_q <= BURST_WIDTH'({beats_q, bus_bit});
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == LEN_LAST) begin
                            cnt_q <= '0;
                            if (rd_wrt) begin
                                state_q <= S_WR_DATA;
                            end else begin
                                rdreq_q <= 1'b1;
                                state_q <= S_RD_REQ;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q < DW_C) sh_q <= DATA_WIDTH'({sh_q, bus_bit});
`ifdef PARITY_EN
                        if (cnt_q == DW_C) begin
                            cnt_q <= '0;
                            if (^{sh_q, bus_bit}) begin
                                err_q   <= 1'b1;
                                state_q <= S_HOLD;
                            end else begin
                                dout_q  <= sh_q;
                                wen_q   <= 1'b1;
                                state_q <= S_WR_STB;
                            end
                        end
`else
                        if (cnt_q == DW_LAST) begin
                            cnt_q   <= '0;
                            dout_q  <= DATA_WIDTH'({sh_q, bus_bit});
                            wen_q   <= 1'b1;
                            state_q <= S_WR_STB;
                        end
`endif
                    end
                    S_WR_STB: begin
                        addr_q <= addr_q + 1'b1;
                        if (beats_q == '0) begin
                            state_q <= S_HOLD;
                        end else begin
                            beats_q <= beats_q - 1'b1;
                            state_q <= S_WR_DATA;
                        end
                    end
                    S_RD_REQ: begin
                        tmo_q <= TW'(1);
                        if (module_dv) begin
                            sh_q    <= data_in_parallel;
                            state_q <= S_RD_GRANT;
                        end else begin
                            state_q <= S_RD_WAIT;
                        end
                    end
                    S_RD_WAIT: begin
                        if (module_dv) begin
                            sh_q    <= data_in_parallel;
                            state_q <= S_RD_GRANT;
                        end else if (tmo_q >= TMO_LAST) begin
                            err_q   <= 1'b1;
                            state_q <= S_HOLD;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    S_RD_GRANT: if (arbiter_cmd_in) begin
                        drv_en_q  <= 1'b1;
                        drv_bit_q <= sh_q[DATA_WIDTH-1];
                        sh_q      <= sh_q << 1;
`ifdef PARITY_EN
                        par_q     <= ^sh_q;
`endif
                        cnt_q     <= '0;
                        state_q   <= S_RD_SHIFT;
                    end
                    S_RD_SHIFT: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == WORD_LAST) begin
                            drv_en_q  <= 1'b0;
                            drv_bit_q <= 1'b0;
                            addr_q    <= addr_q + 1'b1;
                            cnt_q     <= '0;
                            if (beats_q == '0) begin
                                state_q <= S_HOLD;
                            end else begin
                                beats_q <= beats_q - 1'b1;
                                rdreq_q <= 1'b1;
                                state_q <= S_RD_REQ;
                            end
                        end else if (cnt_q < DW_LAST) begin
                            drv_bit_q <= sh_q[DATA_WIDTH-1];
                            sh_q      <= sh_q << 1;
                        end
`ifdef PARITY_EN
                        else drv_bit_q <= par_q;
`endif
                    end
                    S_HOLD: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_burst_serial_slave.sv
// Self-checking bench for burst_serial_slave: directed scenarios plus randomized bursts
// compared against a transaction-level model (expected strobes/read words per beat).
module tb_burst_serial_slave;
    localparam int          AW   = 15;
    localparam int          DW   = 8;
    localparam int          TMO  = 64;
    localparam logic [2:0]  SELF = 3'b110;
`ifdef PARITY_EN
    localparam int          WB   = DW + 1;
`else
    localparam int          WB   = DW;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bus_util = 1'b1, rd_wrt = 1'b0, arb = 1'b0, module_dv = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          m_en = 1'b0, m_bit = 1'b0;
    logic          wen, rdreq, busy, err;
    logic [DW-1:0] dout;
    logic [AW-1:0] addr;
    wire           data_bus;

    int checks = 0, errors = 0, stb_cnt = 0, err_cnt = 0;

    assign data_bus = m_en ? m_bit : 1'bz;
    pullup pu (data_bus);

    always #5 clk = ~clk;

    burst_serial_slave dut (
        .clk(clk), .rst(rst), .bus_util(bus_util), .rd_wrt(rd_wrt),
        .data_bus_serial(data_bus), .arbiter_cmd_in(arb), .module_dv(module_dv),
        .data_in_parallel(data_in), .write_en_internal(wen), .rd_req(rdreq),
        .data_out_parallel(dout), .addr_buff(addr), .busy_out(busy), .err_out(err)
    );

    always @(negedge clk) begin
        if (wen === 1'b1) stb_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic drive_bit(input logic b);
        m_en = 1'b1; m_bit = b;
        @(posedge clk); #1;
    endtask

    task automatic send_header(input logic [2:0] id, input logic [AW-1:0] a,
                               input logic [1:0] len, input logic wr);
        bus_util = 1'b0; rd_wrt = wr;
        for (int i = 2; i >= 0; i--) drive_bit(id[i]);
        for (int i = AW-1; i >= 0; i--) drive_bit(a[i]);
        for (int i = 1; i >= 0; i--) drive_bit(len[i]);
        m_en = 1'b0;
    endtask

    // Called at posedge+1 while the slave sits in HOLD (or is idle).
    task automatic end_txn();
        m_en = 1'b0; bus_util = 1'b1; rd_wrt = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL end_busy: got %b want 0", busy); end
        checks++;
        if (data_bus !== 1'b1) begin errors++; $display("FAIL end_line: got %b want released", data_bus); end
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [1:0] len, input logic [3:0][DW-1:0] w);
        int s0 = stb_cnt;
        logic [AW-1:0] ea;
        send_header(SELF, a, len, 1'b1);
        for (int b = 0; b <= int'(len); b++) begin
            for (int i = DW-1; i >= 0; i--) drive_bit(w[b][i]);
`ifdef PARITY_EN
            drive_bit(^w[b]);
`endif
            m_bit = 1'($urandom_range(0, 1));
            ea = a + AW'(b);
            @(negedge clk);
            checks++;
            if (wen !== 1'b1 || addr !== ea || dout !== w[b]) begin
                errors++;
                $display("FAIL wr_strobe beat %0d: got wen=%b addr=%h data=%h want wen=1 addr=%h data=%h",
                         b, wen, addr, dout, ea, w[b]);
            end
            @(posedge clk); #1;
        end
        m_en = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL wr_hold_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        end_txn();
        checks++;
        if (stb_cnt - s0 != int'(len) + 1)
            begin errors++; $display("FAIL wr_count: got %0d want %0d", stb_cnt - s0, int'(len) + 1); end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [1:0] len, input logic [3:0][DW-1:0] w);
        int lat, g, bad;
        logic [AW-1:0] ea;
        logic [WB-1:0] got, expw;
        send_header(SELF, a, len, 1'b0);
        for (int b = 0; b <= int'(len); b++) begin
            ea  = a + AW'(b);
            lat = $urandom_range(0, 4);
            if (lat == 0) begin module_dv = 1'b1; data_in = w[b]; end
            @(negedge clk);
            checks++;
            if (rdreq !== 1'b1 || addr !== ea) begin
                errors++;
                $display("FAIL rd_req beat %0d: got req=%b addr=%h want req=1 addr=%h", b, rdreq, addr, ea);
            end
            @(posedge clk); #1;
            if (lat != 0) begin
                repeat (lat - 1) begin @(posedge clk); #1; end
                module_dv = 1'b1; data_in = w[b];
                @(posedge clk); #1;
            end
            module_dv = 1'b0; data_in = DW'($urandom);
            g = $urandom_range(0, 3);
            bad = 0;
            repeat (g) begin
                @(negedge clk); if (data_bus !== 1'b1) bad++;
                @(posedge clk); #1;
            end
            arb = 1'b1;
            @(negedge clk); if (data_bus !== 1'b1) bad++;
            @(posedge clk); #1;
            arb = 1'b0;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rd_line_pregrant beat %0d: got %0d driven cycles want 0", b, bad); end
            for (int k = 0; k < WB; k++) begin
                @(negedge clk); got[WB-1-k] = data_bus;
                @(posedge clk); #1;
            end
`ifdef PARITY_EN
            expw = {w[b], ^w[b]};
`else
            expw = w[b];
`endif
            checks++;
            if (got !== expw) begin errors++; $display("FAIL rd_word beat %0d: got %h want %h", b, got, expw); end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || data_bus !== 1'b1)
            begin errors++; $display("FAIL rd_hold: got busy=%b line=%b want busy=1 line released", busy, data_bus); end
        @(posedge clk); #1;
        end_txn();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({wen, rdreq, busy, err} !== 4'b0 || dout !== '0 || addr !== '0 || data_bus !== 1'b1) begin
            errors++;
            $display("FAIL reset: got wen=%b req=%b busy=%b err=%b dout=%h addr=%h line=%b want all 0, line released",
                     wen, rdreq, busy, err, dout, addr, data_bus);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_single();
        do_write(15'h0012, 2'd0, {8'h00, 8'h00, 8'h00, 8'h9F});
    endtask

    task automatic test_write_burst_wrap();
        do_write(15'h7FFE, 2'd3, {8'hD4, 8'hC3, 8'hB2, 8'hA1});
    endtask

    task automatic test_read_burst();
        do_read(15'h0040, 2'd1, {8'h00, 8'h00, 8'h5A, 8'h3C});
    endtask

    task automatic test_id_mismatch();
        int s0 = stb_cnt, bad = 0;
        logic [2:0] id = 3'b101;
        bus_util = 1'b0; rd_wrt = 1'b1;
        for (int i = 2; i >= 0; i--) drive_bit(id[i]);
        m_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); if (busy !== 1'b0 || data_bus !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL id_mismatch_quiet: got %0d bad cycles want 0", bad); end
        end_txn();
        checks++;
        if (stb_cnt != s0) begin errors++; $display("FAIL id_mismatch_strobe: got %0d want %0d", stb_cnt, s0); end
    endtask

    task automatic test_timeout();
        int n = -1, bad = 0, e0 = err_cnt;
        send_header(SELF, 15'h0100, 2'd0, 1'b0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (data_bus !== 1'b1) bad++;
            if (err === 1'b1) begin n = c; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (n < TMO - 1 || n > TMO + 1)
            begin errors++; $display("FAIL timeout_latency: got %0d want about %0d", n, TMO); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL timeout_line: got %0d driven cycles want 0", bad); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL timeout_hold: got err=%b busy=%b want err=0 busy=1", err, busy); end
        @(posedge clk); #1;
        end_txn();
        checks++;
        if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_abort_write();
        int s0 = stb_cnt;
        send_header(SELF, 15'h0333, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)));
        m_en = 1'b0; bus_util = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        repeat (12) begin @(posedge clk); #1; end
        checks++;
        if (stb_cnt != s0) begin errors++; $display("FAIL abort_strobe: got %0d want %0d", stb_cnt, s0); end
        do_write(15'h0444, 2'd0, {8'h00, 8'h00, 8'h00, 8'h66});
    endtask

    task automatic test_reset_mid_read();
        send_header(SELF, 15'h0555, 2'd0, 1'b0);
        module_dv = 1'b1; data_in = 8'h00;
        @(posedge clk); #1;
        module_dv = 1'b0; arb = 1'b1;
        @(posedge clk); #1;
        arb = 1'b0;
        @(negedge clk);
        checks++;
        if (data_bus !== 1'b0) begin errors++; $display("FAIL rst_shift_msb: got %b want 0", data_bus); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; bus_util = 1'b1;
        #1;
        checks++;
        if (data_bus !== 1'b1 || busy !== 1'b0 || rdreq !== 1'b0 || addr !== '0)
            begin errors++; $display("FAIL rst_mid_read: got line=%b busy=%b req=%b addr=%h want released,0,0,0",
                                     data_bus, busy, rdreq, addr); end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        do_write(15'h0001, 2'd0, {8'h00, 8'h00, 8'h00, 8'h81});
    endtask

`ifdef PARITY_EN
    task automatic test_parity_err();
        int s0 = stb_cnt, e0 = err_cnt;
        logic [DW-1:0] d = DW'($urandom);
        send_header(SELF, 15'h0222, 2'd0, 1'b1);
        for (int i = DW-1; i >= 0; i--) drive_bit(d[i]);
        drive_bit(~(^d));
        m_en = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || wen !== 1'b0)
            begin errors++; $display("FAIL parity_err: got err=%b wen=%b want err=1 wen=0", err, wen); end
        @(posedge clk); #1;
        end_txn();
        checks++;
        if (stb_cnt != s0 || err_cnt - e0 != 1)
            begin errors++; $display("FAIL parity_counts: got strobes %0d errs %0d want 0 and 1", stb_cnt - s0, err_cnt - e0); end
    endtask
`endif

    task automatic test_back_to_back_random();
        logic [3:0][DW-1:0] w;
        logic [AW-1:0] a;
        logic [1:0] len;
        for (int t = 0; t < 8; t++) begin
            for (int b = 0; b < 4; b++) w[b] = DW'($urandom);
            a   = (t % 3 == 0) ? AW'(15'h7FFC + AW'($urandom_range(0, 3))) : AW'($urandom);
            len = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) do_write(a, len, w);
            else do_read(a, len, w);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_single();
        test_write_burst_wrap();
        test_read_burst();
        test_id_mismatch();
        test_timeout();
        test_abort_write();
        test_reset_mid_read();
`ifdef PARITY_EN
        test_parity_err();
`endif
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
